// File: rtl/rvi_bits_op_arbiter.sv
// Shares one RVI bits-op exec unit between NUM_REQ requesters, with a one-entry
// response buffer. Define RVI_BITS_OP_ARB_RR_EN for round-robin grant; fixed priority otherwise.
//
// state | meaning
// EMPTY | response buffer holds nothing, rsp_vld=0
// FULL  | response buffer holds a result, rsp_vld=1
module rvi_bits_op_arbiter #(
   parameter int RV64    = 0,
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ),
   localparam int XLEN   = 32 * (RV64 + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_vld,
   output logic [NUM_REQ-1:0]      req_rdy,
   input  logic [2*NUM_REQ-1:0]    req_op,
   input  logic [XLEN*NUM_REQ-1:0] req_s1,
   input  logic [XLEN*NUM_REQ-1:0] req_s2,
   output logic [XLEN-1:0]         ex_s1,
   output logic [XLEN-1:0]         ex_s2,
   output logic                    ex_and_en,
   output logic                    ex_or_en,
   output logic                    ex_xor_en,
   input  logic [XLEN-1:0]         ex_rslt,
   output logic                    rsp_vld,
   input  logic                    rsp_rdy,
   output logic [ID_W-1:0]         rsp_id,
   output logic [XLEN-1:0]         rsp_rslt,
   output logic                    rsp_err
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

   buf_state_t       state, state_nxt;
   logic             accept, take, gnt_any;
   logic [ID_W-1:0]  gnt_id;
   logic [1:0]       sel_op;
   logic [XLEN-1:0]  sel_s1, sel_s2;

`ifdef RVI_BITS_OP_ARB_RR_EN
   logic [ID_W-1:0]  rr_ptr;

   always_comb begin : rr_grant
      int idx;
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_any && req_vld[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (take)
         rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
   end
`else
   always_comb begin : fixed_grant
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!gnt_any && req_vld[k]) begin
            gnt_any = 1'b1;
            gnt_id  = ID_W'(k);
         end
      end
   end
`endif

   always_comb begin
      sel_op = '0;
      sel_s1 = '0;
      sel_s2 = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_id == ID_W'(k)) begin
            sel_op = req_op[2*k +: 2];
            sel_s1 = req_s1[XLEN*k +: XLEN];
            sel_s2 = req_s2[XLEN*k +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (take)
         state_nxt = FULL;
      else if (state == FULL && rsp_rdy)
         state_nxt = EMPTY;
   end

   // accept allows a new request in the same cycle the buffered result drains
   always_comb begin
      rsp_vld   = (state == FULL);
      accept    = rst_n & ((state == EMPTY) | rsp_rdy);
      take      = accept & gnt_any;
      req_rdy   = '0;
      if (take) req_rdy[gnt_id] = 1'b1;
      ex_s1     = take ? sel_s1 : '0;
      ex_s2     = take ? sel_s2 : '0;
      ex_and_en = take && (sel_op == 2'b00);
      ex_or_en  = take && (sel_op == 2'b01);
      ex_xor_en = take && (sel_op == 2'b10);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_id   <= '0;
         rsp_rslt <= '0;
         rsp_err  <= 1'b0;
      end else if (take) begin
         rsp_id   <= gnt_id;
         rsp_err  <= (sel_op == 2'b11);
         rsp_rslt <= (sel_op == 2'b11) ? '0 : ex_rslt;
      end
   end

endmodule

// File: doc/rvi_bits_op_arbiter.md
# rvi_bits_op_arbiter

Shares one RVI bits-op execution unit (AND/OR/XOR over `s1`/`s2`, one-hot `andEn`/`orEn`/`xorEn`, result `rslt`) between `NUM_REQ` requesters. Requests are selected by round-robin, the unit is driven with the selected operands and enables, and the unit's result is captured into a single-entry response buffer with valid/ready backpressure. The block sits between the issue ports of the integer pipe and the bits-op unit. The unit itself is instantiated alongside this block, outside it.

## Interface
- `RV64`, default 0: selects `XLEN = 32*(RV64+1)`.
- `NUM_REQ`, default 2: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester id.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_vld`  in  NUM_REQ  per-requester request valid.
- `req_rdy`  out  NUM_REQ  per-requester accept; at most one bit is high.
- `req_op`  in  2*NUM_REQ  op per requester, 2 bits each: 00 AND, 01 OR, 10 XOR, 11 illegal.
- `req_s1`  in  XLEN*NUM_REQ  operand 1 per requester.
- `req_s2`  in  XLEN*NUM_REQ  operand 2 per requester.
- `ex_s1`, `ex_s2`  out  XLEN  operands to the exec unit.
- `ex_and_en`, `ex_or_en`, `ex_xor_en`  out  1  enables to the exec unit; at most one is high.
- `ex_rslt`  in  XLEN  combinational result from the exec unit.
- `rsp_vld`  out  1  response buffer holds a result.
- `rsp_rdy`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  index of the requester that produced the response.
- `rsp_rslt`  out  XLEN  captured result.
- `rsp_err`  out  1  response came from an illegal op (11).

## Operation
- **Buffer states.** `EMPTY` when `rsp_vld=0`, `FULL` when `rsp_vld=1`.
- **Accept condition.** `accept = !rsp_vld | rsp_rdy`, which allows bypass-drain: a new request is accepted in the same cycle the buffered one drains.
- **Grant.** Round-robin among the asserted `req_vld` bits, searching from pointer `rr_ptr` upward with wrap. This grant is purely combinational.
- **Handshake.** `req_rdy[g] = accept` for the granted index `g`; all other `req_rdy` bits are 0. A request is taken when `req_vld[g] & req_rdy[g]`.
- **Exec drive.** When a request is granted and `accept=1`:
  - `ex_s1`/`ex_s2` carry slice `g` of `req_s1`/`req_s2`.
  - The enable matching `req_op[g]` is high.
  - Op 11 drives all enables 0.
- **Exec idle.** Otherwise all enables are 0 and `ex_s1`/`ex_s2` are 0.
- **Capture on handshake.** `rsp_rslt <= ex_rslt`, `rsp_id <= g`, `rsp_err <= (req_op[g]==2'b11)`, `rsp_vld <= 1`. For op 11, `rsp_rslt` is forced to 0 regardless of `ex_rslt`.
- **Drain without refill.** `rsp_vld & rsp_rdy` with no new handshake gives `rsp_vld <= 0`; data fields hold their last value.
- **Full stall.** `rsp_vld & !rsp_rdy` means all `req_rdy` are 0, and every `rsp_*` output holds stable.
- **Pointer update.** `rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1`, only on a request handshake; otherwise `rr_ptr` holds.
- **Requester rule.** `req_op`/`req_s1`/`req_s2` must be held while `req_vld` is high and `req_rdy` is low. The block does not check this.

## Timing
- Latency is 1 cycle: handshake at edge N makes `rsp_vld` high after edge N.
- Throughput is 1 result per cycle while `rsp_rdy` stays high.
- Reset values: `rsp_vld=0`, `rsp_id=0`, `rsp_rslt=0`, `rsp_err=0`, `rr_ptr=0`. With `req_vld=0`, `req_rdy`=0 and all `ex_*`=0.
- Reset asserted mid-operation discards the buffered result. `req_rdy` is forced to 0 during reset, and no capture happens that cycle.
- Simultaneous drain and refill: the buffer stays `FULL` and the new data replaces the old in the same edge.

## Configuration
- `RVI_BITS_OP_ARB_RR_EN` defined: round-robin grant as described above.
- `RVI_BITS_OP_ARB_RR_EN` undefined:
  - Grant is fixed priority, lowest index wins.
  - `rr_ptr` is not implemented and is not updated.
  - All other behaviour is unchanged.

## Test plan
1. **Single AND.** Reset, then req0 issues AND with `s1=0xF0F0_00FF`, `s2=0x0FF0_0F0F` and `rsp_rdy=1`. Required: `rsp_vld` high next cycle, `rsp_rslt=0x00F0_000F`, `rsp_id=0`, `rsp_err=0`.
2. **Round-robin.** Both requesters valid continuously with `rsp_rdy=1`. Required: grants alternate 0,1,0,1. Without the `_EN` macro, req0 is granted every cycle.
3. **Backpressure.** req1 issues XOR with `s1=0x5`, `s2=0x3`, then `rsp_rdy=0` for 3 cycles while req0 stays valid. Required: `rsp_rslt=0x6` and `rsp_id=1` held stable, `req_rdy=0` throughout. The cycle `rsp_rdy` rises, req0 is accepted with drain and refill in the same edge.
4. **Illegal op.** req0 issues op 11 with `s1=s2=0xFFFF_FFFF`. Required: all `ex_*_en`=0, `rsp_rslt=0`, `rsp_err=1`.
5. **Reset mid-operation.** Assert `rst_n=0` with `rsp_vld=1`. Required: after the edge `rsp_vld=0`, `rsp_rslt=0`, `rr_ptr=0`, and the next grant goes to req0.
6. **OR scoreboard.** 200 random ops with `RV64=1` and random `rsp_rdy`, compared against a software AND/OR/XOR model. Required: zero mismatches, each accepted request responded exactly once and in order.
